mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_access_if.sv | 20 ++
 rtl/mem_lane_align.sv | 42 ++++
 rtl/mem_access.sv | 161 ++++++++++++++++
 tb/tb_mem_access.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage access unit: access sizes, FSM states,
// default timeout and the alignment rule used to reject bad addresses.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is also handled as a word

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Half accesses need addr[0]=0, word accesses need addr[1:0]=0.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addr_lo[0];
      default: return (addr_lo != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory bus between the MEM-stage access unit (master) and memory (slave).
interface mem_access_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store enables/replication and load
// lane extraction with sign or zero extension.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  output logic [3:0]  be,
  output logic [31:0] st_lanes,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Pick the addressed lane, then build enables, replicated store data and extended load data.
  always_comb begin
    ld_byte = ld_raw[{addr_lo, 3'b000} +: 8];
    ld_half = addr_lo[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (size)
      SZ_BYTE: begin
        be       = 4'b0001 << addr_lo;
        st_lanes = {4{st_data[7:0]}};
        ld_data  = is_unsigned ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        st_lanes = {2{st_data[15:0]}};
        ld_data  = is_unsigned ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      default: begin
        be       = '1;
        st_lanes = st_data;
        ld_data  = ld_raw;
      end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM-stage data-memory access unit: passes non-memory ops through, runs
// loads/stores over a req/ack bus with pipeline stall, alignment check and timeout.
module mem_access
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic               MemRead,
  input  logic               MemWrite,
  input  logic               mem_unsigned,
  input  logic [1:0]         mem_size,
  input  logic [31:0]        ALU_result,
  input  logic [31:0]        wData,
  input  logic [4:0]         wAddr_reg,
  input  logic               RegWrite,
  input  logic               MemtoReg,
  mem_access_if.master       dmem,
  output logic               stall,
  output logic [31:0]        rData_mem,
  output logic [31:0]        ALU_result_out,
  output logic [4:0]         wAddr_reg_out,
  output logic               RegWrite_out,
  output logic               MemtoReg_out,
  output logic               out_valid,
  output logic               addr_err,
  output logic               timeout_err
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  state_e      st, st_nx;
  logic [CW-1:0] cnt;
  logic        mem_op, mis, accept, tmo_hit;

  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [4:0]  waddr_q;
  logic [1:0]  size_q;
  logic        we_q, uns_q, regwrite_q, memtoreg_q, tmo_q;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_rdata;

  assign mem_op  = in_valid & (MemRead | MemWrite);
  assign mis     = misaligned(ALU_result[1:0], mem_size);
  assign tmo_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

  mem_lane_align u_lane (
    .addr_lo     (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (uns_q),
    .st_data     (wdata_q),
    .ld_raw      (dmem.dmem_rdata),
    .be          (lane_be),
    .st_lanes    (lane_wdata),
    .ld_data     (lane_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) st <= S_IDLE;
    else     st <= st_nx;
  end

  // Latch the access on accept, count WAIT cycles, capture load data on ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0; addr_q <= '0; wdata_q <= '0; rdata_q <= '0; waddr_q <= '0;
      size_q <= '0; we_q <= 1'b0; uns_q <= 1'b0; regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0; tmo_q <= 1'b0;
    end else begin
      case (st)
        S_IDLE: if (accept) begin
          cnt        <= '0;
          addr_q     <= ALU_result;
          wdata_q    <= wData;
          rdata_q    <= '0;
          waddr_q    <= wAddr_reg;
          size_q     <= mem_size;
          we_q       <= MemWrite;
          uns_q      <= mem_unsigned;
          regwrite_q <= RegWrite;
          memtoreg_q <= MemtoReg;
          tmo_q      <= 1'b0;
        end
        S_WAIT: begin
          if (dmem.dmem_ack) begin
            if (!we_q) rdata_q <= lane_rdata;
          end else if (tmo_hit) begin
            tmo_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Next state, pipeline outputs and bus drive.
  always_comb begin
    st_nx           = st;
    accept          = 1'b0;
    stall           = 1'b0;
    rData_mem       = '0;
    ALU_result_out  = ALU_result;
    wAddr_reg_out   = wAddr_reg;
    RegWrite_out    = RegWrite & in_valid;
    MemtoReg_out    = MemtoReg;
    out_valid       = in_valid;
    addr_err        = 1'b0;
    timeout_err     = 1'b0;
    dmem.dmem_req   = 1'b0;
    dmem.dmem_we    = 1'b0;
    dmem.dmem_addr  = {addr_q[31:2], 2'b00};
    dmem.dmem_wdata = '0;
    dmem.dmem_be    = '0;
    case (st)
      S_IDLE: begin
        if (mem_op && mis) begin
          addr_err     = 1'b1;
          RegWrite_out = 1'b0;
          out_valid    = 1'b1;
        end else if (mem_op) begin
          accept       = 1'b1;
          stall        = 1'b1;
          RegWrite_out = 1'b0;
          out_valid    = 1'b0;
          st_nx        = S_WAIT;
        end
      end
      S_WAIT: begin
        stall           = 1'b1;
        RegWrite_out    = 1'b0;
        out_valid       = 1'b0;
        ALU_result_out  = addr_q;
        wAddr_reg_out   = waddr_q;
        MemtoReg_out    = memtoreg_q;
        dmem.dmem_req   = 1'b1;
        dmem.dmem_we    = we_q;
        dmem.dmem_wdata = lane_wdata;
        dmem.dmem_be    = lane_be;
        if (dmem.dmem_ack || tmo_hit) st_nx = S_DONE;
      end
      S_DONE: begin
        rData_mem      = rdata_q;
        ALU_result_out = addr_q;
        wAddr_reg_out  = waddr_q;
        RegWrite_out   = regwrite_q & ~tmo_q;
        MemtoReg_out   = memtoreg_q;
        out_valid      = 1'b1;
        timeout_err    = tmo_q;
        st_nx          = S_IDLE;
      end
      default: st_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads, stores, alignment,
// timeout and reset-abandon behaviour with hand-computed expectations.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, MemRead, MemWrite, mem_unsigned, RegWrite, MemtoReg;
  logic [1:0]  mem_size;
  logic [31:0] ALU_result, wData;
  logic [4:0]  wAddr_reg;
  logic        stall, RegWrite_out, MemtoReg_out, out_valid, addr_err, timeout_err;
  logic [31:0] rData_mem, ALU_result_out;
  logic [4:0]  wAddr_reg_out;

  int n_cmp = 0;
  int n_err = 0;

  int          n_stall, n_req;
  logic        done_seen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_we;

  mem_access_if bus ();

  mem_access #(.TIMEOUT_CYCLES(255)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .MemRead        (MemRead),
    .MemWrite       (MemWrite),
    .mem_unsigned   (mem_unsigned),
    .mem_size       (mem_size),
    .ALU_result     (ALU_result),
    .wData          (wData),
    .wAddr_reg      (wAddr_reg),
    .RegWrite       (RegWrite),
    .MemtoReg       (MemtoReg),
    .dmem           (bus),
    .stall          (stall),
    .rData_mem      (rData_mem),
    .ALU_result_out (ALU_result_out),
    .wAddr_reg_out  (wAddr_reg_out),
    .RegWrite_out   (RegWrite_out),
    .MemtoReg_out   (MemtoReg_out),
    .out_valid      (out_valid),
    .addr_err       (addr_err),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    in_valid = 0; MemRead = 0; MemWrite = 0; mem_unsigned = 0; mem_size = 2'b10;
    ALU_result = '0; wData = '0; wAddr_reg = '0; RegWrite = 0; MemtoReg = 0;
  endtask

  task automatic next_cyc();
    @(negedge clk);
    bus.dmem_ack = 1'b0;
    #1;
  endtask

  task automatic op(input logic rd, input logic wr, input logic uns, input logic [1:0] sz,
                    input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] wa,
                    input logic rw, input logic m2r);
    in_valid = 1; MemRead = rd; MemWrite = wr; mem_unsigned = uns; mem_size = sz;
    ALU_result = addr; wData = wd; wAddr_reg = wa; RegWrite = rw; MemtoReg = m2r;
    #1;
  endtask

  // Runs from the accept cycle until the DONE cycle; ack on the ack_on-th req cycle (0 = never).
  task automatic run_access(input int ack_on, input logic [31:0] rd);
    n_stall = 0; n_req = 0; done_seen = 0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0 && out_valid) begin
        done_seen = 1;
        break;
      end
      if (stall) n_stall++;
      if (bus.dmem_req) begin
        n_req++;
        if (n_req == 1) begin
          req_addr = bus.dmem_addr; req_wdata = bus.dmem_wdata;
          req_be = bus.dmem_be; req_we = bus.dmem_we;
        end
        if (n_req == ack_on) begin
          bus.dmem_ack = 1'b1; bus.dmem_rdata = rd;
        end
      end
      next_cyc();
    end
    if (!done_seen) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bus.dmem_ack = 0; bus.dmem_rdata = '0;
    idle_in();
    rst = 1;
    next_cyc(); next_cyc();
    rst = 0;
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_aerr", addr_err, 0);
    chk("rst_terr", timeout_err, 0);

    // Non-memory op passes through combinationally
    next_cyc();
    op(0, 0, 0, 2'b10, 32'h12345678, 32'h0, 5'd5, 1, 0);
    chk("pt_alu", ALU_result_out, 32'h12345678);
    chk("pt_rw", RegWrite_out, 1);
    chk("pt_valid", out_valid, 1);
    chk("pt_stall", stall, 0);
    chk("pt_rdata", rData_mem, 0);
    chk("pt_wa", wAddr_reg_out, 5'd5);
    in_valid = 0; #1;
    chk("pt_inv_rw", RegWrite_out, 0);
    chk("pt_inv_valid", out_valid, 0);

    // lw 0x100, ack on third req cycle
    next_cyc();
    op(1, 0, 0, 2'b10, 32'h100, 32'h0, 5'd7, 1, 1);
    chk("lw_acc_stall", stall, 1);
    chk("lw_acc_req", bus.dmem_req, 0);
    run_access(3, 32'hDEADBEEF);
    chk("lw_stall_cycles", n_stall, 4);
    chk("lw_req_cycles", n_req, 3);
    chk("lw_addr", req_addr, 32'h100);
    chk("lw_we", req_we, 0);
    chk("lw_rdata", rData_mem, 32'hDEADBEEF);
    chk("lw_m2r", MemtoReg_out, 1);
    chk("lw_rw", RegWrite_out, 1);
    chk("lw_wa", wAddr_reg_out, 5'd7);
    chk("lw_done_stall", stall, 0);
    chk("lw_done_req", bus.dmem_req, 0);
    idle_in();

    // lb 0x103 signed, minimum latency
    next_cyc();
    op(1, 0, 0, 2'b00, 32'h103, 32'h0, 5'd8, 1, 1);
    run_access(1, 32'h80123456);
    chk("lb_stall_cycles", n_stall, 2);
    chk("lb_addr", req_addr, 32'h100);
    chk("lb_rdata", rData_mem, 32'hFFFFFF80);
    idle_in();

    // lbu 0x103
    next_cyc();
    op(1, 0, 1, 2'b00, 32'h103, 32'h0, 5'd8, 1, 1);
    run_access(1, 32'h80123456);
    chk("lbu_rdata", rData_mem, 32'h00000080);
    idle_in();

    // sh 0x102
    next_cyc();
    op(0, 1, 0, 2'b01, 32'h102, 32'h1234ABCD, 5'd0, 0, 0);
    run_access(2, 32'hFFFFFFFF);
    chk("sh_be", req_be, 4'b1100);
    chk("sh_wdata", req_wdata, 32'hABCDABCD);
    chk("sh_we", req_we, 1);
    chk("sh_addr", req_addr, 32'h100);
    chk("sh_rdata", rData_mem, 0);
    idle_in();

    // MemRead and MemWrite both set: store wins (sb 0x101)
    next_cyc();
    op(1, 1, 0, 2'b00, 32'h101, 32'h000000A5, 5'd3, 0, 0);
    run_access(1, 32'hFFFFFFFF);
    chk("both_we", req_we, 1);
    chk("both_be", req_be, 4'b0010);
    chk("both_wdata", req_wdata, 32'hA5A5A5A5);
    chk("both_rdata", rData_mem, 0);
    idle_in();

    // Misaligned lw 0x101
    next_cyc();
    op(1, 0, 0, 2'b10, 32'h101, 32'h0, 5'd9, 1, 1);
    chk("mis_aerr", addr_err, 1);
    chk("mis_stall", stall, 0);
    chk("mis_rw", RegWrite_out, 0);
    chk("mis_valid", out_valid, 1);
    chk("mis_req", bus.dmem_req, 0);
    // Misaligned lh 0x103
    op(1, 0, 0, 2'b01, 32'h103, 32'h0, 5'd9, 1, 1);
    next_cyc();
    chk("mis_h_aerr", addr_err, 1);
    chk("mis_h_req", bus.dmem_req, 0);
    idle_in(); #1;
    next_cyc();
    chk("mis_pulse_end", addr_err, 0);
    chk("mis_no_req", bus.dmem_req, 0);

    // Timeout: no ack for 255 WAIT cycles
    op(1, 0, 0, 2'b10, 32'h200, 32'h0, 5'd4, 1, 1);
    run_access(0, 32'h0);
    chk("tmo_req_cycles", n_req, 255);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_rw", RegWrite_out, 0);
    chk("tmo_stall", stall, 0);
    chk("tmo_valid", out_valid, 1);
    idle_in();
    next_cyc();
    chk("tmo_pulse_end", timeout_err, 0);

    // Reset during WAIT, late ack ignored
    op(1, 0, 0, 2'b10, 32'h300, 32'h0, 5'd6, 1, 1);
    next_cyc();
    chk("rw_in_wait", bus.dmem_req, 1);
    next_cyc();
    rst = 1; idle_in();
    next_cyc();
    rst = 0; #1;
    chk("rw_req", bus.dmem_req, 0);
    chk("rw_stall", stall, 0);
    next_cyc();
    bus.dmem_ack = 1; bus.dmem_rdata = 32'h11111111; #1;
    chk("rw_ack_valid", out_valid, 0);
    next_cyc();
    chk("rw_after_valid", out_valid, 0);
    chk("rw_after_req", bus.dmem_req, 0);
    op(0, 0, 0, 2'b10, 32'hCAFE0000, 32'h0, 5'd1, 1, 0);
    chk("rw_idle_valid", out_valid, 1);
    chk("rw_idle_stall", stall, 0);
    idle_in();

    // Fresh lhu 0x102 after reset
    next_cyc();
    op(1, 0, 1, 2'b01, 32'h102, 32'h0, 5'd2, 1, 1);
    run_access(1, 32'h80013456);
    chk("lhu_rdata", rData_mem, 32'h00008001);
    idle_in();
    next_cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
